// File: rtl/mem_access_stage_pkg.sv
// Shared CPU definitions for the MEM stage: load/store type encodings, bus size codes,
// the MEM-stage FSM states and the store-side byte-lane helpers.
package mem_access_stage_pkg;

  typedef enum logic [2:0] {
    LdNone = 3'd0,
    LdB    = 3'd1,
    LdBu   = 3'd2,
    LdH    = 3'd3,
    LdHu   = 3'd4,
    LdW    = 3'd5
  } load_type_t;

  typedef enum logic [1:0] {
    StNone = 2'd0,
    StB    = 2'd1,
    StH    = 2'd2,
    StW    = 2'd3
  } store_type_t;

  typedef enum logic [1:0] {
    MemIdle  = 2'd0,
    MemReq   = 2'd1,
    MemWait  = 2'd2,
    MemAbort = 2'd3
  } mem_state_t;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

  function automatic logic [3:0] store_wstrb(store_type_t st, logic [1:0] off);
    case (st)
      StB:     store_wstrb = 4'b0001 << off;
      StH:     store_wstrb = off[1] ? 4'b1100 : 4'b0011;
      StW:     store_wstrb = 4'b1111;
      default: store_wstrb = 4'b0000;
    endcase
  endfunction

  // Replicate the low byte/half across all lanes so the slave picks it by strobe.
  function automatic logic [31:0] store_wdata(store_type_t st, logic [31:0] data);
    case (st)
      StB:     store_wdata = {4{data[7:0]}};
      StH:     store_wdata = {2{data[15:0]}};
      StW:     store_wdata = data;
      default: store_wdata = 32'h0;
    endcase
  endfunction

  function automatic logic [1:0] access_size(load_type_t ld, store_type_t st);
    if (st != StNone) begin
      case (st)
        StB:     access_size = SizeByte;
        StH:     access_size = SizeHalf;
        default: access_size = SizeWord;
      endcase
    end else begin
      case (ld)
        LdB, LdBu: access_size = SizeByte;
        LdH, LdHu: access_size = SizeHalf;
        default:   access_size = SizeWord;
      endcase
    end
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load-data extraction: selects the addressed byte/half from the bus word
// and sign- or zero-extends it.
//   load_type_i : load kind (LdNone/LdW pass the word through)
//   off_i       : byte offset within the word (addr[1:0])
//   rdata_i     : raw bus read data
//   data_o      : extended load result
module mem_load_align
  import mem_access_stage_pkg::*;
(
  input  load_type_t  load_type_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[7:0];
    case (off_i)
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      2'd3:    byte_v = rdata_i[31:24];
      default: byte_v = rdata_i[7:0];
    endcase
    half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (load_type_i)
      LdB:     data_o = {{24{byte_v[7]}}, byte_v};
      LdBu:    data_o = {24'h0, byte_v};
      LdH:     data_o = {{16{half_v[15]}}, half_v};
      LdHu:    data_o = {16'h0, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage. Registers EXE results, issues at most one data-memory access per
// instruction on an SRAM-like req/addr_ok/data_ok bus, stalls while it is outstanding and
// hands result/destination to WB.
//   clk, resetn       : clock, synchronous active-low reset
//   mem_flush, mem_wr : stage clear / stage load enable
//   exe_*             : EXE-stage results for the incoming instruction
//   data_*            : data-memory bus (request side out, addr_ok/data_ok/rdata in)
//   mem_stall         : hold the pipeline while an access is in flight
//   mem_valid, mem_result, mem_dst, mem_regs_wr : towards WB
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_flush,
  input  logic        mem_wr,
  input  logic        exe_valid,
  input  logic [31:0] exe_alu_out,
  input  logic [31:0] exe_out_b,
  input  load_type_t  exe_load_type,
  input  store_type_t exe_store_type,
  input  logic        exe_except,
  input  logic [4:0]  exe_dst,
  input  logic        exe_regs_wr,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        mem_stall,
  output logic        mem_valid,
  output logic [31:0] mem_result,
  output logic [4:0]  mem_dst,
  output logic        mem_regs_wr
);

  mem_state_t  state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  load_type_t  ld_q, ld_d;
  store_type_t st_q, st_d;
  logic [4:0]  dst_q, dst_d;
  logic        regs_wr_q, regs_wr_d;
  logic [31:0] result_q, result_d;

  logic        exe_access;
  logic        load_en;
  logic        capture;
  logic [31:0] load_data;

  mem_load_align u_load_align (
    .load_type_i (ld_q),
    .off_i       (addr_q[1:0]),
    .rdata_i     (data_rdata),
    .data_o      (load_data)
  );

  assign exe_access = exe_valid & ~exe_except &
                      ((exe_load_type != LdNone) | (exe_store_type != StNone));
  // Loads while an access is in flight are illegal; dropping them keeps the fields stable.
  assign load_en    = mem_wr & ~mem_flush & (state_q == MemIdle);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    ld_d      = ld_q;
    st_d      = st_q;
    dst_d     = dst_q;
    regs_wr_d = regs_wr_q;
    result_d  = result_q;
    capture   = 1'b0;

    // Flush kills the instruction but leaves mem_result/addr untouched.
    if (mem_flush) begin
      valid_d   = 1'b0;
      ld_d      = LdNone;
      st_d      = StNone;
      dst_d     = 5'd0;
      regs_wr_d = 1'b0;
    end else if (load_en) begin
      valid_d   = exe_valid;
      addr_d    = exe_alu_out;
      sdata_d   = exe_out_b;
      ld_d      = exe_load_type;
      st_d      = exe_store_type;
      dst_d     = exe_dst;
      regs_wr_d = exe_regs_wr & exe_valid & ~exe_except;
      result_d  = exe_alu_out;
    end

    case (state_q)
      MemIdle: begin
        if (load_en && exe_access) state_d = MemReq;
      end
      MemReq: begin
        if (data_addr_ok) begin
          if (data_data_ok) begin
            state_d = MemIdle;
            capture = ~mem_flush;
          end else begin
            state_d = mem_flush ? MemAbort : MemWait;
          end
        end else if (mem_flush) begin
          state_d = MemIdle;
        end
      end
      MemWait: begin
        if (data_data_ok) begin
          state_d = MemIdle;
          capture = ~mem_flush;
        end else if (mem_flush) begin
          state_d = MemAbort;
        end
      end
      MemAbort: begin
        if (data_data_ok) state_d = MemIdle;
      end
      default: state_d = MemIdle;
    endcase

    if (capture && (ld_q != LdNone)) result_d = load_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= MemIdle;
      valid_q   <= 1'b0;
      addr_q    <= 32'h0;
      sdata_q   <= 32'h0;
      ld_q      <= LdNone;
      st_q      <= StNone;
      dst_q     <= 5'd0;
      regs_wr_q <= 1'b0;
      result_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      ld_q      <= ld_d;
      st_q      <= st_d;
      dst_q     <= dst_d;
      regs_wr_q <= regs_wr_d;
      result_q  <= result_d;
    end
  end

  // Bus fields are only driven while the request is presented.
  always_comb begin
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = SizeByte;
    data_addr  = 32'h0;
    data_wstrb = 4'b0000;
    data_wdata = 32'h0;
    if (state_q == MemReq) begin
      data_req   = 1'b1;
      data_wr    = (st_q != StNone);
      data_size  = access_size(ld_q, st_q);
      data_addr  = addr_q;
      data_wstrb = store_wstrb(st_q, addr_q[1:0]);
      data_wdata = store_wdata(st_q, sdata_q);
    end
  end

  assign mem_stall   = (state_q != MemIdle);
  assign mem_valid   = valid_q;
  assign mem_result  = result_q;
  assign mem_dst     = dst_q;
  assign mem_regs_wr = regs_wr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a vector table of single-cycle bus transactions
// plus hand-written sequences for split responses, flush, exceptions and reset.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk;
  logic        resetn;
  logic        mem_flush;
  logic        mem_wr;
  logic        exe_valid;
  logic [31:0] exe_alu_out;
  logic [31:0] exe_out_b;
  load_type_t  exe_load_type;
  store_type_t exe_store_type;
  logic        exe_except;
  logic [4:0]  exe_dst;
  logic        exe_regs_wr;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_stall;
  logic        mem_valid;
  logic [31:0] mem_result;
  logic [4:0]  mem_dst;
  logic        mem_regs_wr;

  int total = 0;
  int bad   = 0;

  mem_access_stage dut (
    .clk            (clk),
    .resetn         (resetn),
    .mem_flush      (mem_flush),
    .mem_wr         (mem_wr),
    .exe_valid      (exe_valid),
    .exe_alu_out    (exe_alu_out),
    .exe_out_b      (exe_out_b),
    .exe_load_type  (exe_load_type),
    .exe_store_type (exe_store_type),
    .exe_except     (exe_except),
    .exe_dst        (exe_dst),
    .exe_regs_wr    (exe_regs_wr),
    .data_req       (data_req),
    .data_wr        (data_wr),
    .data_size      (data_size),
    .data_addr      (data_addr),
    .data_wstrb     (data_wstrb),
    .data_wdata     (data_wdata),
    .data_addr_ok   (data_addr_ok),
    .data_data_ok   (data_data_ok),
    .data_rdata     (data_rdata),
    .mem_stall      (mem_stall),
    .mem_valid      (mem_valid),
    .mem_result     (mem_result),
    .mem_dst        (mem_dst),
    .mem_regs_wr    (mem_regs_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (resetn && mem_wr && !mem_flush)
      assert (!mem_stall) else $error("mem_wr issued while stage is stalled");
  end

  typedef struct {
    load_type_t  ld;
    store_type_t st;
    logic [31:0] addr;
    logic [31:0] b;
    logic [31:0] rdata;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_result;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the loading edge.
  task automatic issue(input load_type_t ld, input store_type_t st, input logic [31:0] addr,
                       input logic [31:0] b, input logic [4:0] dst, input logic rw,
                       input logic exc);
    exe_valid      = 1'b1;
    exe_load_type  = ld;
    exe_store_type = st;
    exe_alu_out    = addr;
    exe_out_b      = b;
    exe_dst        = dst;
    exe_regs_wr    = rw;
    exe_except     = exc;
    mem_wr         = 1'b1;
    @(negedge clk);
    mem_wr     = 1'b0;
    exe_valid  = 1'b0;
    exe_except = 1'b0;
  endtask

  initial begin
    vecs[0] = '{LdNone, StB, 32'h8000_0003, 32'h1234_56AB, 32'hFFFF_FFFF, 1'b1, 2'd0,
                4'b1000, 32'hABAB_ABAB, 32'h8000_0003};
    vecs[1] = '{LdNone, StH, 32'h8000_0002, 32'h0000_BEEF, 32'hFFFF_FFFF, 1'b1, 2'd1,
                4'b1100, 32'hBEEF_BEEF, 32'h8000_0002};
    vecs[2] = '{LdNone, StW, 32'h8000_0010, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b1, 2'd2,
                4'b1111, 32'hCAFE_F00D, 32'h8000_0010};
    vecs[3] = '{LdH, StNone, 32'h0000_0102, 32'h1111_1111, 32'h8001_7FFF, 1'b0, 2'd1,
                4'b0000, 32'h0, 32'hFFFF_8001};
    vecs[4] = '{LdBu, StNone, 32'h0000_0201, 32'h1111_1111, 32'h0000_F000, 1'b0, 2'd0,
                4'b0000, 32'h0, 32'h0000_00F0};
    vecs[5] = '{LdB, StNone, 32'h0000_0200, 32'h1111_1111, 32'h0000_0080, 1'b0, 2'd0,
                4'b0000, 32'h0, 32'hFFFF_FF80};
    vecs[6] = '{LdHu, StNone, 32'h0000_0300, 32'h1111_1111, 32'h1234_8765, 1'b0, 2'd1,
                4'b0000, 32'h0, 32'h0000_8765};
    vecs[7] = '{LdW, StNone, 32'h0000_0404, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0, 2'd2,
                4'b0000, 32'h0, 32'hDEAD_BEEF};
    vecs[8] = '{LdB, StNone, 32'h0000_0503, 32'h1111_1111, 32'h7F00_0000, 1'b0, 2'd0,
                4'b0000, 32'h0, 32'h0000_007F};

    // Reset with the bus acknowledging and a load offered: everything must stay zero.
    resetn         = 1'b0;
    mem_flush      = 1'b0;
    mem_wr         = 1'b1;
    exe_valid      = 1'b1;
    exe_alu_out    = 32'h0000_1000;
    exe_out_b      = 32'h0;
    exe_load_type  = LdW;
    exe_store_type = StNone;
    exe_except     = 1'b0;
    exe_dst        = 5'd3;
    exe_regs_wr    = 1'b1;
    data_addr_ok   = 1'b1;
    data_data_ok   = 1'b1;
    data_rdata     = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    check("rst_req", data_req, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_valid", mem_valid, 0);
    check("rst_result", mem_result, 0);
    check("rst_dst", mem_dst, 0);
    check("rst_regs_wr", mem_regs_wr, 0);
    check("rst_bus", {data_wr, data_size, data_wstrb}, 0);
    check("rst_addr", data_addr, 0);
    check("rst_wdata", data_wdata, 0);
    mem_wr       = 1'b0;
    exe_valid    = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    resetn       = 1'b1;
    @(negedge clk);

    // Table: accept and respond in the request cycle.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].b, 5'(i + 1), 1'b1, 1'b0);
      check("v_req", data_req, 1);
      check("v_wr", data_wr, vecs[i].exp_wr);
      check("v_size", data_size, vecs[i].exp_size);
      check("v_addr", data_addr, vecs[i].addr);
      check("v_wstrb", data_wstrb, vecs[i].exp_wstrb);
      check("v_wdata", data_wdata, vecs[i].exp_wdata);
      check("v_stall_busy", mem_stall, 1);
      data_addr_ok = 1'b1;
      data_data_ok = 1'b1;
      data_rdata   = vecs[i].rdata;
      @(negedge clk);
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      check("v_stall_rel", mem_stall, 0);
      check("v_req_off", data_req, 0);
      check("v_result", mem_result, vecs[i].exp_result);
      check("v_valid", mem_valid, 1);
      check("v_dst", mem_dst, 32'(i + 1));
      check("v_regs_wr", mem_regs_wr, 1);
    end

    // SB with data_ok before addr_ok (ignored), then split addr_ok / data_ok.
    issue(LdNone, StB, 32'h8000_0003, 32'h1234_56AB, 5'd3, 1'b0, 1'b0);
    check("sb_wstrb", data_wstrb, 4'b1000);
    check("sb_wdata", data_wdata, 32'hABAB_ABAB);
    data_data_ok = 1'b1;
    data_rdata   = 32'h5555_5555;
    @(negedge clk);
    check("sb_early_dok_req", data_req, 1);
    data_data_ok = 1'b0;
    data_addr_ok = 1'b1;
    @(negedge clk);
    check("sb_wait_req", data_req, 0);
    check("sb_wait_stall", mem_stall, 1);
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    @(negedge clk);
    data_data_ok = 1'b0;
    check("sb_stall_rel", mem_stall, 0);
    check("sb_result", mem_result, 32'h8000_0003);

    // Flush in WAIT: abort, swallow the late response.
    issue(LdW, StNone, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b0);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    mem_flush    = 1'b1;
    @(negedge clk);
    mem_flush = 1'b0;
    check("abort_stall", mem_stall, 1);
    check("abort_valid", mem_valid, 0);
    check("abort_regs_wr", mem_regs_wr, 0);
    check("abort_req", data_req, 0);
    data_data_ok = 1'b1;
    data_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    data_data_ok = 1'b0;
    check("abort_done_stall", mem_stall, 0);
    check("abort_result", mem_result, 32'h0000_0100);
    check("abort_done_valid", mem_valid, 0);

    // Flush in REQ without addr_ok: request withdrawn.
    issue(LdW, StNone, 32'h0000_0200, 32'h0, 5'd8, 1'b1, 1'b0);
    mem_flush = 1'b1;
    @(negedge clk);
    mem_flush = 1'b0;
    check("wdraw_stall", mem_stall, 0);
    check("wdraw_req", data_req, 0);
    check("wdraw_valid", mem_valid, 0);

    // Exception on a LW: no access, no GPR write.
    issue(LdW, StNone, 32'h0000_0300, 32'h0, 5'd9, 1'b1, 1'b1);
    check("exc_req", data_req, 0);
    check("exc_stall", mem_stall, 0);
    check("exc_regs_wr", mem_regs_wr, 0);
    check("exc_result", mem_result, 32'h0000_0300);

    // ALU-only op: zero stall, result is the ALU value.
    issue(LdNone, StNone, 32'h0000_55AA, 32'h0, 5'd10, 1'b1, 1'b0);
    check("alu_stall", mem_stall, 0);
    check("alu_req", data_req, 0);
    check("alu_result", mem_result, 32'h0000_55AA);
    check("alu_dst", mem_dst, 10);
    check("alu_regs_wr", mem_regs_wr, 1);

    // Reset during WAIT; a response arriving afterwards must be ignored.
    issue(LdW, StNone, 32'h0000_0400, 32'h0, 5'd11, 1'b1, 1'b0);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    resetn       = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("mrst_stall", mem_stall, 0);
    check("mrst_result", mem_result, 0);
    data_data_ok = 1'b1;
    data_rdata   = 32'h1234_5678;
    @(negedge clk);
    data_data_ok = 1'b0;
    check("mrst_late_stall", mem_stall, 0);
    check("mrst_late_result", mem_result, 0);
    check("mrst_late_valid", mem_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
